// File: rtl/owt_sym_pkg.sv
// Shared types and helpers for the OWT symbol decoder.
// Symbol classes, decoder states, error codes and window checks.
package owt_sym_pkg;

    typedef enum logic [1:0] {
        SYM_NONE = 2'd0,
        SYM_BIT0 = 2'd1,
        SYM_BIT1 = 2'd2,
        SYM_SYNC = 2'd3
    } sym_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } dec_st_e;

    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_PAR  = 2'b10;
    localparam logic [1:0] ERR_SYNC = 2'b11;

    function automatic logic in_win(
        input int unsigned v,
        input int unsigned lo,
        input int unsigned hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic win_disjoint(
        input int a_lo,
        input int a_hi,
        input int b_lo,
        input int b_hi
    );
        return (a_hi < b_lo) || (b_hi < a_lo);
    endfunction

endpackage

// File: rtl/owt_sym_classify.sv
// Combinational interval classifier: maps a measured length to
// SYNC, BIT1, BIT0 or NONE using inclusive windows.
module owt_sym_classify
    import owt_sym_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int SYNC_MIN = 40,
    parameter int SYNC_MAX = 60,
    parameter int BIT1_MIN = 18,
    parameter int BIT1_MAX = 24,
    parameter int BIT0_MIN = 8,
    parameter int BIT0_MAX = 12
) (
    input  logic [LEN_W-1:0] i_len,
    output sym_type_e        o_type
);

    int unsigned len;

    always_comb begin
        len    = 32'(i_len);
        o_type = SYM_NONE;
        // Zero length never classifies, even if a window starts at 0.
        if (len == 0) begin
            o_type = SYM_NONE;
        end else if (in_win(len, SYNC_MIN, SYNC_MAX)) begin
            o_type = SYM_SYNC;
        end else if (in_win(len, BIT1_MIN, BIT1_MAX)) begin
            o_type = SYM_BIT1;
        end else if (in_win(len, BIT0_MIN, BIT0_MAX)) begin
            o_type = SYM_BIT0;
        end
    end

endmodule

// File: rtl/owt_symbol_decode.sv
// OWT symbol decoder: collects SYNC + FRM_BITS data bits + even parity
// and reports each frame or abort as a single-cycle pulse.
module owt_symbol_decode
    import owt_sym_pkg::*;
#(
    parameter int CNT_OWT_EXT_CYC_W = 8,
    parameter int SYNC_MIN          = 40,
    parameter int SYNC_MAX          = 60,
    parameter int BIT1_MIN          = 18,
    parameter int BIT1_MAX          = 24,
    parameter int BIT0_MIN          = 8,
    parameter int BIT0_MAX          = 12,
    parameter int FRM_BITS          = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_dec_en,
    input  logic                         i_sym_vld,
    input  logic [CNT_OWT_EXT_CYC_W-1:0] i_sym_len,
    output logic                         o_frm_vld,
    output logic [FRM_BITS-1:0]          o_frm_data,
    output logic                         o_frm_err,
    output logic [1:0]                   o_err_code,
    output logic                         o_busy
);

    localparam int CW = $clog2(FRM_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(FRM_BITS - 1);

`ifdef ASSERT_ON
    if (SYNC_MIN > SYNC_MAX) begin : g_bad_sync
        $error("SYNC window MIN > MAX");
    end
    if (BIT1_MIN > BIT1_MAX) begin : g_bad_bit1
        $error("BIT1 window MIN > MAX");
    end
    if (BIT0_MIN > BIT0_MAX) begin : g_bad_bit0
        $error("BIT0 window MIN > MAX");
    end
    if (!win_disjoint(SYNC_MIN, SYNC_MAX, BIT1_MIN, BIT1_MAX) ||
        !win_disjoint(SYNC_MIN, SYNC_MAX, BIT0_MIN, BIT0_MAX) ||
        !win_disjoint(BIT1_MIN, BIT1_MAX, BIT0_MIN, BIT0_MAX))
    begin : g_overlap
        $error("symbol windows overlap");
    end
    if (FRM_BITS < 1 || FRM_BITS > 32) begin : g_bad_frm
        $error("FRM_BITS out of range 1..32");
    end
`endif

    sym_type_e          sym;
    dec_st_e            state;
    dec_st_e            state_nxt;
    logic [CW-1:0]      bit_cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [FRM_BITS-1:0] shreg;
    logic [FRM_BITS-1:0] shreg_nxt;
    logic [FRM_BITS-1:0] data_nxt;
    logic               par;
    logic               par_nxt;
    logic               vld_nxt;
    logic               err_nxt;
    logic [1:0]         code_nxt;
    logic               bit_val;
    logic               is_bit;
    logic               clr;

    owt_sym_classify #(
        .LEN_W    (CNT_OWT_EXT_CYC_W),
        .SYNC_MIN (SYNC_MIN),
        .SYNC_MAX (SYNC_MAX),
        .BIT1_MIN (BIT1_MIN),
        .BIT1_MAX (BIT1_MAX),
        .BIT0_MIN (BIT0_MIN),
        .BIT0_MAX (BIT0_MAX)
    ) u_classify (
        .i_len  (i_sym_len),
        .o_type (sym)
    );

    assign o_busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        data_nxt  = o_frm_data;
        code_nxt  = o_err_code;
        clr       = 1'b0;
        bit_val   = (sym == SYM_BIT1);
        is_bit    = (sym == SYM_BIT0) || (sym == SYM_BIT1);

        if (!i_dec_en) begin
            state_nxt = ST_IDLE;
            clr       = 1'b1;
        end else if (i_sym_vld) begin
            unique case (state)
                ST_IDLE: begin
                    if (sym == SYM_SYNC) begin
                        state_nxt = ST_DATA;
                        clr       = 1'b1;
                    end
                end
                ST_DATA, ST_PAR: begin
                    if (sym == SYM_SYNC) begin
                        // A SYNC mid-frame aborts and opens a fresh frame.
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_SYNC;
                        state_nxt = ST_DATA;
                        clr       = 1'b1;
                    end else if (!is_bit) begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_LEN;
                        state_nxt = ST_IDLE;
                        clr       = 1'b1;
                    end else if (state == ST_DATA) begin
                        shreg_nxt = (shreg << 1) | FRM_BITS'(bit_val);
                        par_nxt   = par ^ bit_val;
                        cnt_nxt   = bit_cnt + CW'(1);
                        if (bit_cnt == LAST) begin
                            state_nxt = ST_PAR;
                        end
                    end else begin
                        if (par ^ bit_val) begin
                            err_nxt  = 1'b1;
                            code_nxt = ERR_PAR;
                        end else begin
                            vld_nxt  = 1'b1;
                            data_nxt = shreg;
                        end
                        state_nxt = ST_IDLE;
                        clr       = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    clr       = 1'b1;
                end
            endcase
        end

        if (clr) begin
            cnt_nxt   = '0;
            shreg_nxt = '0;
            par_nxt   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            o_frm_vld  <= 1'b0;
            o_frm_err  <= 1'b0;
            o_frm_data <= '0;
            o_err_code <= 2'b00;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= cnt_nxt;
            shreg      <= shreg_nxt;
            par        <= par_nxt;
            o_frm_vld  <= vld_nxt;
            o_frm_err  <= err_nxt;
            o_frm_data <= data_nxt;
            o_err_code <= code_nxt;
        end
    end

endmodule
